regmap_arbiter: RTL

Shares the single register-map access port between `NUM_REQ` host-side requesters, such as the SPI slave and the debug UART bridge. Arbitrates the requests, latches the winning transaction, and drives the register-map port with the multi-cycle hold sequence that port requires. Returns a one-cycle response, with read data, to the winning requester. Sits between the host interface front-ends and `register_map` in the top level.

---
 rtl/regmap_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/regmap_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/regmap_arb_pkg.sv
// Shared types, hold constants and address-range helpers for the register-map arbiter.
package regmap_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } regmap_arb_state_e;

  // The register map commits a write only on the third consecutive enable cycle
  localparam int unsigned WR_HOLD = 3;
  localparam int unsigned RD_HOLD = 2;

  function automatic logic addr_is_config(input logic [31:0] addr, input int unsigned num_config);
    return addr < num_config;
  endfunction

  function automatic logic addr_in_map(input logic [31:0] addr, input int unsigned num_config,
                                       input int unsigned num_status);
    return addr < (num_config + num_status);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot requester arbiter. REGMAP_ARB_RR_EN selects round-robin with a pointer register;
// otherwise it is a fixed-priority encoder where the lowest index wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

`ifdef REGMAP_ARB_RR_EN
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned IDX_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nxt;
  logic             found;

  // Search starts at the pointer and wraps; the pointer moves past the winner
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    nxt   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'(ptr_q) + IDX_W'(i);
      if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found                 = 1'b1;
        grant[idx[PTR_W-1:0]] = 1'b1;
        nxt                   = idx + IDX_W'(1);
        ptr_d                 = (nxt == IDX_W'(NUM_REQ)) ? '0 : nxt[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk_i, rst_i, advance};

  // Isolate the lowest set bit
  assign grant = req & (~req + NUM_REQ'(1));
`endif

endmodule

// File: rtl/regmap_arbiter.sv
// Shares the register-map port between NUM_REQ requesters with the map's multi-cycle hold
// sequence. Arbitration policy is set by REGMAP_ARB_RR_EN (round-robin) in rr_arbiter.
module regmap_arbiter
  import regmap_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_CONFIG_REG = 96,
  parameter int unsigned NUM_STATUS_REG = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic                          rsp_err_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          busy_o,
  output logic [ADDR_WIDTH-1:0]         rm_addr_o,
  output logic [DATA_WIDTH-1:0]         rm_write_data_o,
  output logic                          rm_write_en_o,
  output logic                          rm_read_en_o,
  input  logic [DATA_WIDTH-1:0]         rm_read_data_i
);

  localparam int unsigned CNT_W = $clog2(WR_HOLD);

  regmap_arb_state_e state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    winner_q, winner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    rsp_valid_d;
  logic                  rsp_err_d;
  logic                  busy_d;
  logic [ADDR_WIDTH-1:0] rm_addr_d;
  logic [DATA_WIDTH-1:0] rm_wdata_d;
  logic                  rm_we_d;
  logic                  rm_re_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [NUM_REQ-1:0]    grant_c;
  logic                  advance;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req_valid_i),
    .advance (advance),
    .grant   (arb_grant)
  );

  // Grants are only offered from IDLE, so a request raised during RESP waits one cycle
  assign grant_c     = (state_q == IDLE && !rst_i) ? arb_grant : '0;
  assign req_ready_o = grant_c;

  // Winner's request fields, selected by the one-hot grant
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_c[k]) begin
        sel_we    = sel_we | req_we_i[k];
        sel_addr  = sel_addr | req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = sel_wdata | req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|grant_c) begin
          advance  = 1'b1;
          winner_d = grant_c;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          if (sel_we) begin
            state_d = WRITE;
            cnt_d   = CNT_W'(WR_HOLD - 1);
            err_d   = !addr_is_config(32'(sel_addr), NUM_CONFIG_REG);
          end else begin
            state_d = READ;
            cnt_d   = CNT_W'(RD_HOLD - 1);
            err_d   = !addr_in_map(32'(sel_addr), NUM_CONFIG_REG, NUM_STATUS_REG);
          end
        end
      end
      WRITE, READ: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs follow the state being entered; rm_* are zero outside WRITE/READ
    busy_d      = (state_d != IDLE);
    rm_we_d     = (state_d == WRITE) && !err_d;
    rm_re_d     = (state_d == READ);
    rm_addr_d   = (state_d == WRITE || state_d == READ) ? addr_d : '0;
    rm_wdata_d  = (state_d == WRITE) ? wdata_d : '0;
    rsp_valid_d = (state_d == RESP) ? winner_d : '0;
    rsp_err_d   = (state_d == RESP) && err_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      winner_q        <= '0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      err_q           <= 1'b0;
      busy_o          <= 1'b0;
      rm_write_en_o   <= 1'b0;
      rm_read_en_o    <= 1'b0;
      rm_addr_o       <= '0;
      rm_write_data_o <= '0;
      rsp_valid_o     <= '0;
      rsp_err_o       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      winner_q        <= winner_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      err_q           <= err_d;
      busy_o          <= busy_d;
      rm_write_en_o   <= rm_we_d;
      rm_read_en_o    <= rm_re_d;
      rm_addr_o       <= rm_addr_d;
      rm_write_data_o <= rm_wdata_d;
      rsp_valid_o     <= rsp_valid_d;
      rsp_err_o       <= rsp_err_d;
    end
  end

  // Read data is passed through from the map while the response is presented
  assign rsp_rdata_o = (state_q == RESP && !we_q) ? rm_read_data_i : '0;

endmodule
